uart_rx_fifo_ctrl: RTL and testbench

UART_RX_FIFO_CTRL -- requirements
Module: uart_rx_fifo_ctrl

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive FIFO controller:
//   UART_FIFO_DEPTH : FIFO depth in bytes (power of two)
//   UART_FIFO_AW    : pointer width, log2(UART_FIFO_DEPTH)
//   wr_state_e      : write (receiver handshake) FSM states
//   rd_state_e      : read (CPU pop) FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 512;
  localparam int UART_FIFO_AW    = 9;

  typedef enum logic {
    W_IDLE      = 1'b0,
    W_WAIT_DROP = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_CAP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Byte FIFO controller between a UART receiver and a CPU, storing data in an
// external single-cycle-latency block RAM.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   byte_valid, byte_data   level-signalled byte from the receiver
//   byte_ack                four-phase acknowledge back to the receiver
//   mem_wen/mem_wa/mem_wd   BRAM write port
//   mem_ren/mem_ra/mem_rd   BRAM read port (mem_rd valid one cycle after ren)
//   pop_req                 CPU request for one byte
//   pop_valid, pop_data     one-cycle pulse with the popped byte (3-cycle latency)
//   level, empty, full      stored byte count and its decodes
//   overflow                sticky: a byte was dropped because the FIFO was full
//   clear                   synchronous flush, highest priority
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ack,
  output logic          mem_wen,
  output logic [AW-1:0] mem_wa,
  output logic [7:0]    mem_wd,
  output logic          mem_ren,
  output logic [AW-1:0] mem_ra,
  input  logic [7:0]    mem_rd,
  input  logic          pop_req,
  output logic          pop_valid,
  output logic [7:0]    pop_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  input  logic          clear
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  wr_state_e     r_wr_state;
  rd_state_e     r_rd_state;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic          r_byte_ack;
  logic          r_mem_wen;
  logic [AW-1:0] r_mem_wa;
  logic [7:0]    r_mem_wd;
  logic          r_mem_ren;
  logic [AW-1:0] r_mem_ra;
  logic          r_pop_valid;
  logic [7:0]    r_pop_data;
  logic [AW:0]   r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic [AW:0]   w_level_next;

  // ---------------------------------------------------------------------------
  // Write side: one byte per byte_valid assertion. The FSM only decides in
  // W_IDLE, which is at least two cycles after the previous mem_wen, so the
  // level register already reflects that write when full is consulted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state <= W_IDLE;
      r_wptr     <= '0;
      r_byte_ack <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_mem_wa   <= '0;
      r_mem_wd   <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_state <= W_IDLE;
      r_wptr     <= '0;
      r_byte_ack <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_mem_wen <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          if (byte_valid) begin
            r_byte_ack <= 1'b1;
            r_wr_state <= W_WAIT_DROP;
            if (!r_full) begin
              r_mem_wen <= 1'b1;
              r_mem_wa  <= r_wptr;
              r_mem_wd  <= byte_data;
              r_wptr    <= r_wptr + AW'(1);
            end else begin
              // Byte is acknowledged and discarded so the receiver never stalls.
              r_overflow <= 1'b1;
            end
          end
        end
        W_WAIT_DROP: begin
          if (!byte_valid) begin
            r_byte_ack <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: R_IDLE issues the BRAM read, R_MEM waits for the RAM latency,
  // R_CAP registers mem_rd into pop_data. The FSM is back in R_IDLE before
  // the next decision, by which time level has absorbed the previous read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state  <= R_IDLE;
      r_rptr      <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_ra    <= '0;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
    end else if (clear) begin
      r_rd_state  <= R_IDLE;
      r_rptr      <= '0;
      r_mem_ren   <= 1'b0;
      r_pop_valid <= 1'b0;
    end else begin
      r_mem_ren   <= 1'b0;
      r_pop_valid <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (pop_req && !r_empty) begin
            r_mem_ren  <= 1'b1;
            r_mem_ra   <= r_rptr;
            r_rptr     <= r_rptr + AW'(1);
            r_rd_state <= R_MEM;
          end
        end
        R_MEM: r_rd_state <= R_CAP;
        R_CAP: begin
          r_pop_valid <= 1'b1;
          r_pop_data  <= mem_rd;
          r_rd_state  <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shared occupancy counter, driven by the registered strobes so it counts
  // committed RAM operations. empty/full are registered alongside it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_level_next = r_level;
    case ({r_mem_wen, r_mem_ren})
      2'b10:   w_level_next = r_level + (AW+1)'(1);
      2'b01:   w_level_next = r_level - (AW+1)'(1);
      default: w_level_next = r_level;
    endcase
    if (clear) begin
      w_level_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_level <= w_level_next;
      r_empty <= (w_level_next == '0);
      r_full  <= (w_level_next == DEPTH_L);
    end
  end

  assign byte_ack  = r_byte_ack;
  assign mem_wen   = r_mem_wen;
  assign mem_wa    = r_mem_wa;
  assign mem_wd    = r_mem_wd;
  assign mem_ren   = r_mem_ren;
  assign mem_ra    = r_mem_ra;
  assign pop_valid = r_pop_valid;
  assign pop_data  = r_pop_data;
  assign level     = r_level;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
// Directed bench for uart_rx_fifo_ctrl with an attached BRAM model. A
// queue-based FIFO model predicts every output each cycle; directed
// scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = UART_FIFO_DEPTH;
  localparam int AW    = UART_FIFO_AW;

  logic          clk;
  logic          reset_n;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ack;
  logic          mem_wen;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;
  logic          mem_ren;
  logic [AW-1:0] mem_ra;
  logic [7:0]    mem_rd;
  logic          pop_req;
  logic          pop_valid;
  logic [7:0]    pop_data;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          clear;

  uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ack(byte_ack),
    .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_ren(mem_ren), .mem_ra(mem_ra), .mem_rd(mem_rd),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .level(level), .empty(empty), .full(full), .overflow(overflow),
    .clear(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM attached to the controller
  logic [7:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) bram[mem_wa] <= mem_wd;
    if (mem_ren) mem_rd <= bram[mem_ra];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: contents as a queue, writes/reads as counts,
  // pop latency as a countdown.
  // ---------------------------------------------------------------------------
  logic          m_wen, m_ren, m_ack, m_pv, m_ovf, m_busy;
  logic [AW-1:0] m_wa, m_ra;
  logic [7:0]    m_wd, m_pd, m_pend;
  int            m_level, m_wcnt, m_rcnt, m_pcnt, m_nl;
  logic [7:0]    m_q[$];

  task automatic model_reset(input bit keep_pd);
    m_wen = 0; m_ren = 0; m_ack = 0; m_pv = 0; m_ovf = 0; m_busy = 0;
    m_level = 0; m_wcnt = 0; m_rcnt = 0; m_pcnt = 0;
    m_q.delete();
    if (!keep_pd) begin
      m_wa = '0; m_ra = '0; m_wd = '0; m_pd = '0;
    end
  endtask

  initial begin
    model_reset(1'b0);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset(1'b0);
      end else if (clear) begin
        model_reset(1'b1);
      end else begin
        m_nl = m_level + (m_wen ? 1 : 0) - (m_ren ? 1 : 0);
        m_wen = 0;
        if (!m_busy) begin
          if (byte_valid) begin
            if (m_level < DEPTH) begin
              m_wen = 1;
              m_wa  = AW'(m_wcnt % DEPTH);
              m_wd  = byte_data;
              m_q.push_back(byte_data);
              m_wcnt++;
            end else begin
              m_ovf = 1;
            end
            m_busy = 1;
          end
        end else if (!byte_valid) begin
          m_busy = 0;
        end
        m_ack = m_busy;
        m_ren = 0;
        m_pv  = 0;
        if (m_pcnt == 0) begin
          if (pop_req && m_level > 0) begin
            m_ren  = 1;
            m_ra   = AW'(m_rcnt % DEPTH);
            m_rcnt++;
            m_pend = m_q.pop_front();
            m_pcnt = 2;
          end
        end else begin
          m_pcnt--;
          if (m_pcnt == 0) begin
            m_pv = 1;
            m_pd = m_pend;
          end
        end
        m_level = m_nl;
      end
    end
  end

  // Per-cycle comparison against the model
  bit cmp_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_ack", 32'(byte_ack), 32'(m_ack));
        chk("m_wen", 32'(mem_wen), 32'(m_wen));
        if (m_wen) begin
          chk("m_wa", 32'(mem_wa), 32'(m_wa));
          chk("m_wd", 32'(mem_wd), 32'(m_wd));
        end
        chk("m_ren", 32'(mem_ren), 32'(m_ren));
        if (m_ren) chk("m_ra", 32'(mem_ra), 32'(m_ra));
        chk("m_pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("m_pop_data", 32'(pop_data), 32'(m_pd));
        chk("m_level", 32'(level), 32'(m_level));
        chk("m_empty", 32'(empty), 32'(m_level == 0));
        chk("m_full", 32'(full), 32'(m_level == DEPTH));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
      end
    end
  end

  // Event monitor used by the directed literal checks
  int         wen_cnt = 0, ren_cnt = 0, pv_cnt = 0;
  logic [AW-1:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_wen === 1'b1) begin wen_cnt++; last_wa = mem_wa; last_wd = mem_wd; end
      if (mem_ren === 1'b1) ren_cnt++;
      if (pop_valid === 1'b1) pv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    tick();
    while (!byte_ack && k < 8) begin tick(); k++; end
    if (!byte_ack) chk("send_ack_rise_timeout", 32'(byte_ack), 32'd1);
    byte_valid = 1'b0;
    k = 0;
    tick();
    while (byte_ack && k < 8) begin tick(); k++; end
    if (byte_ack) chk("send_ack_fall_timeout", 32'(byte_ack), 32'd0);
    $display("tx byte %02h level=%0d", b, level);
  endtask

  task automatic pop_byte(output logic [7:0] d);
    int k;
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    k = 0;
    while (!pop_valid && k < 6) begin tick(); k++; end
    if (!pop_valid) chk("pop_valid_timeout", 32'(pop_valid), 32'd1);
    d = pop_data;
    $display("pop byte %02h level=%0d", d, level);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    $display("clear level=%0d overflow=%0b", level, overflow);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] d;
  int         c0, c1;

  initial begin
    reset_n = 1'b0; byte_valid = 1'b0; byte_data = '0;
    pop_req = 1'b0; clear = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ack", 32'(byte_ack), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    $display("reset checked");
    reset_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    // Single byte 0xA5 with a held byte_valid, then one pop
    byte_valid = 1'b1; byte_data = 8'hA5;
    tick();
    chk("single_ack", 32'(byte_ack), 32'd1);
    chk("single_wen", 32'(mem_wen), 32'd1);
    chk("single_wa", 32'(mem_wa), 32'd0);
    chk("single_wd", 32'(mem_wd), 32'hA5);
    tick();
    chk("single_ack_held", 32'(byte_ack), 32'd1);
    chk("single_wen_once", 32'(mem_wen), 32'd0);
    chk("single_level1", 32'(level), 32'd1);
    byte_valid = 1'b0;
    tick();
    chk("single_ack_drop", 32'(byte_ack), 32'd0);
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    chk("single_ren", 32'(mem_ren), 32'd1);
    chk("single_ra", 32'(mem_ra), 32'd0);
    tick();
    chk("single_pv_early", 32'(pop_valid), 32'd0);
    chk("single_level0", 32'(level), 32'd0);
    tick();
    chk("single_pv", 32'(pop_valid), 32'd1);
    chk("single_pd", 32'(pop_data), 32'hA5);
    tick();
    chk("single_pv_pulse", 32'(pop_valid), 32'd0);
    $display("single byte A5 done");

    // Fill to 512 and drop byte 513
    do_clear();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
    tick();
    chk("fill_level", 32'(level), 32'd512);
    chk("fill_full", 32'(full), 32'd1);
    c0 = wen_cnt;
    send_byte(8'h77);
    chk("drop_no_wen", 32'(wen_cnt), 32'(c0));
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_level", 32'(level), 32'd512);

    // Wrap: pop 1, write 1 at address 0, then drain in order
    pop_byte(d);
    chk("wrap_first_pop", 32'(d), 32'h00);
    tick();
    send_byte(8'hC3);
    chk("wrap_wa", 32'(last_wa), 32'd0);
    chk("wrap_wd", 32'(last_wd), 32'hC3);
    tick();
    chk("wrap_level", 32'(level), 32'd512);
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte(d);
      if (i == 0) chk("wrap_pop0", 32'(d), 32'h01);
      if (i == DEPTH - 1) chk("wrap_pop_last", 32'(d), 32'hC3);
    end
    tick();
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Clear while a pop is in its R_MEM cycle
    send_byte(8'h31);
    send_byte(8'h32);
    tick();
    c0 = pv_cnt;
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) tick();
    chk("clrpop_no_pv", 32'(pv_cnt), 32'(c0));
    chk("clrpop_level", 32'(level), 32'd0);
    chk("clrpop_empty", 32'(empty), 32'd1);
    chk("clrpop_overflow", 32'(overflow), 32'd0);
    $display("clear during pop done");

    // Simultaneous write and read at level 5
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
    tick();
    chk("sim_level5", 32'(level), 32'd5);
    byte_valid = 1'b1; byte_data = 8'h20; pop_req = 1'b1;
    tick();
    chk("sim_wen", 32'(mem_wen), 32'd1);
    chk("sim_ren", 32'(mem_ren), 32'd1);
    byte_valid = 1'b0; pop_req = 1'b0;
    tick();
    chk("sim_level_same", 32'(level), 32'd5);
    tick();
    chk("sim_pv", 32'(pop_valid), 32'd1);
    chk("sim_pd", 32'(pop_data), 32'h10);
    for (int i = 0; i < 5; i++) pop_byte(d);
    chk("sim_last_pop", 32'(d), 32'h20);
    tick();
    chk("sim_empty", 32'(empty), 32'd1);
    c0 = ren_cnt; c1 = pv_cnt;
    pop_req = 1'b1;
    repeat (2) tick();
    pop_req = 1'b0;
    repeat (4) tick();
    chk("empty_pop_no_ren", 32'(ren_cnt), 32'(c0));
    chk("empty_pop_no_pv", 32'(pv_cnt), 32'(c1));
    $display("simultaneous / empty pop done");

    // Async reset during W_WAIT_DROP, byte_valid held through release
    byte_valid = 1'b1; byte_data = 8'h5C;
    tick();
    chk("arst_ack_before", 32'(byte_ack), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_ack_now", 32'(byte_ack), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("arst_wen", 32'(mem_wen), 32'd1);
    chk("arst_wa", 32'(mem_wa), 32'd0);
    chk("arst_wd", 32'(mem_wd), 32'h5C);
    byte_valid = 1'b0;
    repeat (2) tick();
    chk("arst_level1", 32'(level), 32'd1);
    $display("async reset mid-handshake done");

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
